// File: rtl/sprite_pkg.sv
// Shared sprite-path defaults and the one-hot requester tag type, reused by the
// display units, the ROM wrapper and the sprite ROM arbiter.
package sprite_pkg;

  localparam int N_REQ_DFLT   = 4;
  localparam int ADDR_W_DFLT  = 10;
  localparam int DATA_W_DFLT  = 12;
  localparam int ROM_LAT_DFLT = 1;

  // One bit per requester; at most one bit set.
  typedef logic [N_REQ_DFLT-1:0] tag_t;

  // Next requester index after i, wrapping at n.
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational rotate-priority picker: searches req upward from ptr with wrap
// and returns the one-hot winner plus its index.
module rr_arbiter_pick
  import sprite_pkg::*;
#(
  parameter int N_REQ = N_REQ_DFLT,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] idx,
  output logic             found
);

  int               cand;
  logic [PTR_W-1:0] cand_idx;

  // NOTE: every output gets a default before the loop, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = PTR_W'(cand);
      if (!found && req[cand_idx]) begin
        found         = 1'b1;
        gnt[cand_idx] = 1'b1;
        idx           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin share of the sprite ROM read port with a one-hot tag pipeline
// that steers each returned word. Define SPRITE_ARB_OUTREG_EN to register rd_data/rd_valid.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DFLT,
  parameter int ADDR_W  = ADDR_W_DFLT,
  parameter int DATA_W  = DATA_W_DFLT,
  parameter int ROM_LAT = ROM_LAT_DFLT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]       rd_data
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0] ptr_q, ptr_d, win_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic             win_found;
  logic [N_REQ-1:0] tag_q [ROM_LAT];
  logic [N_REQ-1:0] tag_d [ROM_LAT];

  rr_arbiter_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (win_idx),
    .found (win_found)
  );

  // gnt is already a subset of req, so any grant bit is a transfer.
  always_comb begin
    gnt      = rst ? '0 : pick_gnt;
    rom_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) rom_addr = addr[i*ADDR_W +: ADDR_W];
    end
    ptr_d = (win_found && !rst) ? PTR_W'(wrap_inc(int'(win_idx), N_REQ)) : ptr_q;
    tag_d[0] = gnt;
    for (int s = 1; s < ROM_LAT; s++) tag_d[s] = tag_q[s-1];
  end

  // NOTE: the tag stages are control state, not storage: every stage is reset
  // so a read in flight at reset can never raise rd_valid afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      for (int s = 0; s < ROM_LAT; s++) tag_q[s] <= '0;
    end else begin
      // NOTE: non-blocking so every stage shifts on the same edge.
      ptr_q <= ptr_d;
      for (int s = 0; s < ROM_LAT; s++) tag_q[s] <= tag_d[s];
    end
  end

`ifdef SPRITE_ARB_OUTREG_EN
  logic [N_REQ-1:0]  rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_valid_d = tag_q[ROM_LAT-1];
    rd_data_d  = (|tag_q[ROM_LAT-1]) ? rom_data : rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
`else
  assign rd_valid = tag_q[ROM_LAT-1];
  assign rd_data  = rom_data;
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a behavioural ROM of latency ROM_LAT.
module tb_sprite_rom_arbiter;

  localparam int ROM_LAT = 1;
`ifdef SPRITE_ARB_OUTREG_EN
  localparam int LAT = ROM_LAT + 1;
`else
  localparam int LAT = ROM_LAT;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [39:0] addr;
  logic [3:0]  gnt;
  logic [9:0]  rom_addr;
  logic [11:0] rom_data;
  logic [3:0]  rd_valid;
  logic [11:0] rd_data;

  int n_vec  = 0;
  int n_miss = 0;

  logic [3:0]  ev [LAT];
  logic [11:0] ed [LAT];
  logic [11:0] rp [ROM_LAT];

  sprite_rom_arbiter #(
    .N_REQ(4), .ADDR_W(10), .DATA_W(12), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .addr     (addr),
    .gnt      (gnt),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] word(input logic [9:0] a);
    return (a == 10'h155) ? 12'hABC : {2'b00, a};
  endfunction

  always @(posedge clk) begin
    rp[0] <= word(rom_addr);
    for (int s = 1; s < ROM_LAT; s++) rp[s] <= rp[s-1];
  end
  assign rom_data = rp[ROM_LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_pipe();
    for (int s = 0; s < LAT; s++) begin
      ev[s] = '0;
      ed[s] = '0;
    end
  endtask

  // One pixel cycle: drive, check combinational outputs and due returns, then clock.
  task automatic cycle(input logic [3:0] r, input logic [39:0] a, input logic [3:0] eg);
    logic [9:0] ea;
    ea   = '0;
    req  = r;
    addr = a;
    #1;
    for (int i = 0; i < 4; i++) if (eg[i]) ea = a[i*10 +: 10];
    check("gnt", 32'(gnt), 32'(eg));
    check("rom_addr", 32'(rom_addr), 32'(ea));
    check("rd_valid", 32'(rd_valid), 32'(ev[LAT-1]));
    if (ev[LAT-1] != 4'b0) check("rd_data", 32'(rd_data), 32'(ed[LAT-1]));
    @(posedge clk);
    for (int s = LAT - 1; s > 0; s--) begin
      ev[s] = ev[s-1];
      ed[s] = ed[s-1];
    end
    ev[0] = eg;
    ed[0] = word(ea);
    #2;
  endtask

  logic [39:0] rr_addr;
  logic [39:0] one_addr;

  initial begin
    rr_addr = {10'h103, 10'h102, 10'h101, 10'h100};
    clear_pipe();
    rst  = 1'b1;
    req  = 4'hF;
    addr = rr_addr;
    #2;

    // Reset holds every output quiet even with all requesters active.
    cycle(4'hF, rr_addr, 4'b0000);
    cycle(4'hF, rr_addr, 4'b0000);
    rst = 1'b0;

    // Round-robin from ptr 0: 0,1,2,3,0,1,2,3.
    cycle(4'hF, rr_addr, 4'b0001);
    cycle(4'hF, rr_addr, 4'b0010);
    cycle(4'hF, rr_addr, 4'b0100);
    cycle(4'hF, rr_addr, 4'b1000);
    cycle(4'hF, rr_addr, 4'b0001);
    cycle(4'hF, rr_addr, 4'b0010);
    cycle(4'hF, rr_addr, 4'b0100);
    cycle(4'hF, rr_addr, 4'b1000);

    // Single requester 2 at 0x155 returns 0xABC.
    one_addr = {10'h000, 10'h155, 10'h000, 10'h000};
    cycle(4'b0100, one_addr, 4'b0100);
    for (int k = 0; k <= LAT; k++) cycle(4'b0000, one_addr, 4'b0000);

    // Rotation skip: grant 1, then req 0011 wraps past idle 2,3 to 0, then 1.
    cycle(4'b0010, rr_addr, 4'b0010);
    cycle(4'b0011, rr_addr, 4'b0001);
    cycle(4'b0011, rr_addr, 4'b0010);

    // Back-to-back on requester 0, addresses 0..4, words 0..4 in order.
    for (int k = 0; k < 5; k++) cycle(4'b0001, {30'b0, 10'(k)}, 4'b0001);
    for (int k = 0; k <= LAT; k++) cycle(4'b0000, rr_addr, 4'b0000);

    // Mid-flight reset: the read granted to 3 must never come back.
    cycle(4'b1000, rr_addr, 4'b1000);
    rst = 1'b1;
    clear_pipe();
    cycle(4'b1000, rr_addr, 4'b0000);
    cycle(4'b1000, rr_addr, 4'b0000);
    rst = 1'b0;
    for (int k = 0; k <= LAT + 1; k++) cycle(4'b0000, rr_addr, 4'b0000);

    // Pointer restarted at 0.
    cycle(4'hF, rr_addr, 4'b0001);
    for (int k = 0; k <= LAT; k++) cycle(4'b0000, rr_addr, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
